// File: rtl/pwm_ctrl_pkg.sv
// Shared register map, ramp_ctrl bit positions and ramp state encoding.
// Pure declarations; no latency.
// No handshake; consumers decode directly.
package pwm_ctrl_pkg;

    localparam logic [6:0] ADDR_EN_OUT_LO = 7'h00;
    localparam logic [6:0] ADDR_EN_OUT_HI = 7'h01;
    localparam logic [6:0] ADDR_EN_PWM_LO = 7'h02;
    localparam logic [6:0] ADDR_EN_PWM_HI = 7'h03;
    localparam logic [6:0] ADDR_DUTY      = 7'h04;
    localparam logic [6:0] ADDR_RAMP_CTRL = 7'h05;
    localparam logic [6:0] ADDR_RAMP_STEP = 7'h06;
    localparam logic [6:0] ADDR_RAMP_DIV  = 7'h07;
    localparam logic [6:0] ADDR_RAMP_LO   = 7'h08;
    localparam logic [6:0] ADDR_RAMP_HI   = 7'h09;

    localparam int CTRL_EN_BIT   = 0;
    localparam int CTRL_MODE_BIT = 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_UP   = 2'd1,
        ST_DOWN = 2'd2
    } ramp_state_t;

endpackage

// File: rtl/ramp_tick_gen.sv
// Prescaler: tick is high while count == div, giving one tick every div+1 cycles.
// Tick is combinational from the count register; clr restarts the period next cycle.
// No backpressure; free-running.
module ramp_tick_gen (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic [7:0] div,
    output logic       tick
);

    logic [7:0] count;

    assign tick = (count == div);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= 8'd0;
        end else if (clr || tick) begin
            count <= 8'd0;
        end else begin
            count <= count + 8'd1;
        end
    end

endmodule

// File: rtl/pwm_ramp_ctrl.sv
// PWM enable/duty register block with a triangle/sawtooth duty ramp engine.
// Register writes are visible one cycle after the strobe; ramp steps land one cycle after a tick.
// No backpressure: every write strobe is accepted; a host duty write overrides a coincident tick.
module pwm_ramp_ctrl
    import pwm_ctrl_pkg::*;
#(
    parameter int NUM_REGS = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_valid,
    input  logic [6:0] wr_addr,
    input  logic [7:0] wr_data,
    output logic [7:0] en_reg_out_7_0,
    output logic [7:0] en_reg_out_15_8,
    output logic [7:0] en_reg_pwm_7_0,
    output logic [7:0] en_reg_pwm_15_8,
    output logic [7:0] pwm_duty_cycle,
    output logic       ramp_active,
    output logic       wr_collision
);

    logic [7:0]  ramp_step, ramp_div, ramp_lo, ramp_hi;
    logic        ctrl_en, ctrl_mode;
    ramp_state_t state, state_nxt;
    logic [7:0]  duty_nxt;
    logic        tick, tick_use;
    logic        wr_hit, ctrl_wr, duty_wr, en_rise, en_fall;
    logic [8:0]  up_sum, dn_diff;

    assign wr_hit  = wr_valid && (32'(wr_addr) < NUM_REGS);
    assign ctrl_wr = wr_hit && (wr_addr == ADDR_RAMP_CTRL);
    assign duty_wr = wr_hit && (wr_addr == ADDR_DUTY);
    assign en_rise = ctrl_wr && wr_data[CTRL_EN_BIT] && !ctrl_en;
    assign en_fall = ctrl_wr && !wr_data[CTRL_EN_BIT];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en_reg_out_7_0  <= 8'h00;
            en_reg_out_15_8 <= 8'h00;
            en_reg_pwm_7_0  <= 8'h00;
            en_reg_pwm_15_8 <= 8'h00;
            ctrl_en         <= 1'b0;
            ctrl_mode       <= 1'b0;
            ramp_step       <= 8'h00;
            ramp_div        <= 8'h00;
            ramp_lo         <= 8'h00;
            ramp_hi         <= 8'h00;
        end else if (wr_hit) begin
            case (wr_addr)
                ADDR_EN_OUT_LO: en_reg_out_7_0  <= wr_data;
                ADDR_EN_OUT_HI: en_reg_out_15_8 <= wr_data;
                ADDR_EN_PWM_LO: en_reg_pwm_7_0  <= wr_data;
                ADDR_EN_PWM_HI: en_reg_pwm_15_8 <= wr_data;
                ADDR_RAMP_CTRL: begin
                    ctrl_en   <= wr_data[CTRL_EN_BIT];
                    ctrl_mode <= wr_data[CTRL_MODE_BIT];
                end
                ADDR_RAMP_STEP: ramp_step <= wr_data;
                ADDR_RAMP_DIV:  ramp_div  <= wr_data;
                ADDR_RAMP_LO:   ramp_lo   <= wr_data;
                ADDR_RAMP_HI:   ramp_hi   <= wr_data;
                default: ;
            endcase
        end
    end

    ramp_tick_gen u_tick (
        .clk  (clk),
        .rst  (rst),
        .clr  (en_rise),
        .div  (ramp_div),
        .tick (tick)
    );

    assign tick_use = tick && ramp_active;
    // 9-bit arithmetic so saturation is detected instead of wrapping.
    assign up_sum   = {1'b0, pwm_duty_cycle} + {1'b0, ramp_step};
    assign dn_diff  = {1'b0, pwm_duty_cycle} - {1'b0, ramp_step};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= ST_IDLE;
            pwm_duty_cycle <= 8'h00;
            wr_collision   <= 1'b0;
        end else begin
            state          <= state_nxt;
            pwm_duty_cycle <= duty_nxt;
            wr_collision   <= duty_wr && tick_use;
        end
    end

    always_comb begin
        state_nxt = state;
        duty_nxt  = pwm_duty_cycle;
        if (en_fall) begin
            state_nxt = ST_IDLE;
        end else if (en_rise) begin
            state_nxt = ST_UP;
            duty_nxt  = ramp_lo;
        end else if (duty_wr) begin
            duty_nxt = wr_data;
        end else if (tick_use) begin
            if (ramp_lo >= ramp_hi) begin
                duty_nxt  = ramp_lo;
                state_nxt = ST_UP;
            end else if (ramp_step == 8'h00) begin
                duty_nxt = pwm_duty_cycle;
            end else if (state == ST_UP) begin
                if (ctrl_mode && (pwm_duty_cycle >= ramp_hi)) begin
                    duty_nxt = ramp_lo;
                end else begin
                    duty_nxt = (up_sum > {1'b0, ramp_hi}) ? ramp_hi : up_sum[7:0];
                    if (!ctrl_mode && (duty_nxt == ramp_hi)) begin
                        state_nxt = ST_DOWN;
                    end
                end
            end else begin
                duty_nxt = (dn_diff[8] || (dn_diff[7:0] < ramp_lo)) ? ramp_lo : dn_diff[7:0];
                if (duty_nxt == ramp_lo) begin
                    state_nxt = ST_UP;
                end
            end
        end
    end

    always_comb begin
        ramp_active = (state == ST_UP) || (state == ST_DOWN);
    end

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Directed plus randomized bench for pwm_ramp_ctrl against an arithmetic reference model.
module tb_pwm_ramp_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       wr_valid = 1'b0;
    logic [6:0] wr_addr = 7'h00;
    logic [7:0] wr_data = 8'h00;
    logic [7:0] en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8;
    logic [7:0] pwm_duty_cycle;
    logic       ramp_active, wr_collision;

    pwm_ramp_ctrl #(.NUM_REGS(10)) dut (
        .clk             (clk),
        .rst             (rst),
        .wr_valid        (wr_valid),
        .wr_addr         (wr_addr),
        .wr_data         (wr_data),
        .en_reg_out_7_0  (en_reg_out_7_0),
        .en_reg_out_15_8 (en_reg_out_15_8),
        .en_reg_pwm_7_0  (en_reg_pwm_7_0),
        .en_reg_pwm_15_8 (en_reg_pwm_15_8),
        .pwm_duty_cycle  (pwm_duty_cycle),
        .ramp_active     (ramp_active),
        .wr_collision    (wr_collision)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;
    int fails  = 0;

    // Reference model: register image, run flag, direction, and the edge the ramp started on.
    logic [7:0] m_regs [0:9];
    bit         m_run, m_up, m_coll;
    int         edge_n = 0;
    int         en_edge = 0;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 10; i++) m_regs[i] = 8'h00;
        m_run  = 1'b0;
        m_up   = 1'b1;
        m_coll = 1'b0;
    endtask

    task automatic model_edge(input bit v, input logic [6:0] a, input logic [7:0] d);
        int ai, dv, lo, hi, st, duty, nd;
        bit saw, tick;
        edge_n++;
        if (rst) begin
            model_reset();
            return;
        end
        ai   = int'(a);
        dv   = int'(m_regs[7]);
        st   = int'(m_regs[6]);
        lo   = int'(m_regs[8]);
        hi   = int'(m_regs[9]);
        duty = int'(m_regs[4]);
        saw  = m_regs[5][1];
        tick = m_run && (((edge_n - en_edge - 1) % (dv + 1)) == dv);
        m_coll = 1'b0;
        if (v && ai < 10) begin
            if (ai == 5) begin
                if (!d[0]) m_run = 1'b0;
                else if (!m_run) begin
                    m_run = 1'b1;
                    m_up = 1'b1;
                    m_regs[4] = m_regs[8];
                    en_edge = edge_n;
                end
                m_regs[5] = d;
            end else if (ai == 4) begin
                m_coll = tick;
                tick = 1'b0;
                m_regs[4] = d;
            end else begin
                m_regs[ai] = d;
            end
        end
        if (tick && m_run) begin
            if (lo >= hi) begin
                nd = lo;
                m_up = 1'b1;
            end else if (st == 0) begin
                nd = duty;
            end else if (m_up) begin
                if (saw && duty >= hi) nd = lo;
                else begin
                    nd = (duty + st > hi) ? hi : duty + st;
                    if (!saw && nd == hi) m_up = 1'b0;
                end
            end else begin
                nd = (duty - st < lo) ? lo : duty - st;
                if (nd == lo) m_up = 1'b1;
            end
            m_regs[4] = 8'(nd);
        end
    endtask

    task automatic cyc(input bit v, input logic [6:0] a, input logic [7:0] d);
        @(negedge clk);
        wr_valid = v;
        wr_addr  = a;
        wr_data  = d;
        @(posedge clk);
        model_edge(v, a, d);
        #1;
        chk("duty", pwm_duty_cycle, m_regs[4]);
        chk("ramp_active", 8'(ramp_active), 8'(m_run));
        chk("wr_collision", 8'(wr_collision), 8'(m_coll));
        chk("en_out_lo", en_reg_out_7_0, m_regs[0]);
        chk("en_out_hi", en_reg_out_15_8, m_regs[1]);
        chk("en_pwm_lo", en_reg_pwm_7_0, m_regs[2]);
        chk("en_pwm_hi", en_reg_pwm_15_8, m_regs[3]);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 7'h00, 8'h00);
    endtask

    task automatic setup(input logic [7:0] lo, input logic [7:0] hi, input logic [7:0] st,
                         input logic [7:0] dv);
        cyc(1'b1, 7'h05, 8'h00);
        cyc(1'b1, 7'h08, lo);
        cyc(1'b1, 7'h09, hi);
        cyc(1'b1, 7'h06, st);
        cyc(1'b1, 7'h07, dv);
    endtask

    // Enable the ramp, then check the duty seen right after the enable and after each tick.
    task automatic run_seq(input string tag, input logic [7:0] ctrl, input int dv,
                           input logic [7:0] exp[$]);
        cyc(1'b1, 7'h05, ctrl);
        chk(tag, pwm_duty_cycle, exp[0]);
        for (int i = 1; i < exp.size(); i++) begin
            idle(dv + 1);
            chk(tag, pwm_duty_cycle, exp[i]);
        end
    endtask

    initial begin
        logic [7:0] tri_seq[$] = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h30, 8'h20, 8'h10, 8'h20};
        logic [7:0] sat_seq[$] = '{8'h00, 8'h60, 8'hC0, 8'hFF, 8'h9F, 8'h3F, 8'h00};
        logic [7:0] saw_seq[$] = '{8'h10, 8'h20, 8'h30, 8'h10, 8'h20};
        logic [7:0] held;
        int lo, hi, r, md;

        model_reset();
        #1 rst = 1'b1;
        #1;
        chk("reset_duty", pwm_duty_cycle, 8'h00);
        chk("reset_active", 8'(ramp_active), 8'h00);
        chk("reset_coll", 8'(wr_collision), 8'h00);
        chk("reset_en_out_lo", en_reg_out_7_0, 8'h00);
        @(negedge clk);
        rst = 1'b0;

        cyc(1'b1, 7'h00, 8'hA5);
        cyc(1'b1, 7'h01, 8'h5A);
        cyc(1'b1, 7'h02, 8'h3C);
        cyc(1'b1, 7'h03, 8'hC3);
        chk("en_pwm_hi_write", en_reg_pwm_15_8, 8'hC3);
        cyc(1'b1, 7'h04, 8'h22);
        chk("idle_duty_write", pwm_duty_cycle, 8'h22);
        chk("idle_duty_no_coll", 8'(wr_collision), 8'h00);

        setup(8'h10, 8'h40, 8'h10, 8'd3);
        run_seq("triangle", 8'h01, 3, tri_seq);

        setup(8'h00, 8'hFF, 8'h60, 8'd1);
        run_seq("saturate", 8'h01, 1, sat_seq);

        setup(8'h10, 8'h30, 8'h10, 8'd2);
        run_seq("sawtooth", 8'h03, 2, saw_seq);

        // Host duty write landing on a tick edge.
        setup(8'h10, 8'hF0, 8'h10, 8'd3);
        cyc(1'b1, 7'h05, 8'h01);
        idle(3);
        cyc(1'b1, 7'h04, 8'h80);
        chk("collision_duty", pwm_duty_cycle, 8'h80);
        chk("collision_pulse", 8'(wr_collision), 8'h01);
        idle(1);
        chk("collision_pulse_end", 8'(wr_collision), 8'h00);
        idle(3);
        chk("collision_resume", pwm_duty_cycle, 8'h90);

        // Disable mid-ramp at 0x30.
        setup(8'h10, 8'h40, 8'h10, 8'd3);
        cyc(1'b1, 7'h05, 8'h01);
        idle(8);
        chk("pre_disable", pwm_duty_cycle, 8'h30);
        cyc(1'b1, 7'h05, 8'h00);
        chk("disable_duty", pwm_duty_cycle, 8'h30);
        chk("disable_active", 8'(ramp_active), 8'h00);
        idle(10);
        chk("disable_hold", pwm_duty_cycle, 8'h30);

        cyc(1'b1, 7'h0A, 8'h55);
        cyc(1'b1, 7'h7F, 8'h55);
        chk("invalid_addr_duty", pwm_duty_cycle, 8'h30);

        // ramp_lo >= ramp_hi forces lo on each tick.
        setup(8'h50, 8'h20, 8'h10, 8'd1);
        cyc(1'b1, 7'h05, 8'h01);
        cyc(1'b1, 7'h04, 8'h60);
        idle(1);
        chk("lo_ge_hi_duty", pwm_duty_cycle, 8'h50);
        chk("lo_ge_hi_active", 8'(ramp_active), 8'h01);

        // Step zero while ramping.
        setup(8'h10, 8'h80, 8'h10, 8'd1);
        cyc(1'b1, 7'h05, 8'h01);
        idle(4);
        cyc(1'b1, 7'h06, 8'h00);
        held = m_regs[4];
        idle(20);
        chk("step_zero_hold", pwm_duty_cycle, held);
        chk("step_zero_active", 8'(ramp_active), 8'h01);

        // Randomized configurations and traffic.
        for (int k = 0; k < 8; k++) begin
            lo = $urandom_range(0, 200);
            hi = $urandom_range(lo + 1, 255);
            md = $urandom_range(0, 1);
            setup(8'(lo), 8'(hi), 8'($urandom_range(1, 90)), 8'($urandom_range(0, 4)));
            cyc(1'b1, 7'h05, 8'(1 | (md << 1)));
            for (int c = 0; c < 80; c++) begin
                r = $urandom_range(0, 99);
                if (r < 8) cyc(1'b1, 7'h04, 8'($urandom_range(0, 255)));
                else if (r < 12) cyc(1'b1, 7'h06, 8'($urandom_range(0, 90)));
                else if (r < 16) cyc(1'b1, 7'($urandom_range(0, 3)), 8'($urandom));
                else if (r < 20) cyc(1'b1, 7'($urandom_range(10, 127)), 8'($urandom));
                else if (r < 22) cyc(1'b1, 7'h05, 8'(1 | ($urandom_range(0, 1) << 1)));
                else cyc(1'b0, 7'h00, 8'h00);
            end
        end

        // Asynchronous reset in the middle of a ramp.
        setup(8'h20, 8'hE0, 8'h10, 8'd1);
        cyc(1'b1, 7'h05, 8'h01);
        idle(5);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_duty", pwm_duty_cycle, 8'h00);
        chk("async_rst_active", 8'(ramp_active), 8'h00);
        chk("async_rst_coll", 8'(wr_collision), 8'h00);
        chk("async_rst_en_out_lo", en_reg_out_7_0, 8'h00);
        chk("async_rst_en_out_hi", en_reg_out_15_8, 8'h00);
        chk("async_rst_en_pwm_lo", en_reg_pwm_7_0, 8'h00);
        chk("async_rst_en_pwm_hi", en_reg_pwm_15_8, 8'h00);
        model_reset();
        idle(2);
        @(negedge clk);
        rst = 1'b0;
        idle(12);
        chk("post_rst_idle", 8'(ramp_active), 8'h00);
        chk("post_rst_duty", pwm_duty_cycle, 8'h00);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/pwm_ramp_ctrl.md
PWM_RAMP_CTRL -- requirements
Module: pwm_ramp_ctrl

Interface
REQ-001 Parameter NUM_REGS, default 10: number of decoded register addresses (0x00-0x09).
REQ-002 clk  input  1  single clock for all sequential logic.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 wr_valid  input  1  one-cycle register-write strobe from the SPI peripheral.
REQ-005 wr_addr  input  7  register address of the write.
REQ-006 wr_data  input  8  register write data.
REQ-007 en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8  output  8 each  registered PWM enable registers.
REQ-008 pwm_duty_cycle  output  8  registered duty value driven to the PWM peripheral.
REQ-009 ramp_active  output  1  high while the state is UP or DOWN.
REQ-010 wr_collision  output  1  one-cycle pulse when a host duty write coincides with a ramp tick.

Function
REQ-011 Register map: 0x00-0x03 enable registers; 0x04 duty; 0x05 ramp_ctrl (bit0 enable, bit1 mode: 0 = triangle, 1 = sawtooth); 0x06 ramp_step; 0x07 ramp_div; 0x08 ramp_lo; 0x09 ramp_hi.
REQ-012 A write to any other address is ignored with no side effects.
REQ-013 A write sampled on cycle N is visible on the outputs on cycle N+1.
REQ-014 Tick generator: an 8-bit counter counts 0..ramp_div and asserts tick when count == ramp_div; the tick period is ramp_div+1 cycles.
REQ-015 The tick counter is cleared on any ramp_ctrl write that takes enable from 0 to 1.
REQ-016 States are IDLE, UP, DOWN.
REQ-017 IDLE -> UP on an enable 0->1 write; the same write loads pwm_duty_cycle with ramp_lo; the first tick follows ramp_div+1 cycles later.
REQ-018 Any state -> IDLE on a ramp_ctrl write with enable = 0; duty freezes at its current value.
REQ-019 UP on tick: duty = min(duty + ramp_step, ramp_hi), computed in 9 bits (no 8-bit wrap).
REQ-020 On reaching ramp_hi in triangle mode, the next state is DOWN.
REQ-021 On reaching ramp_hi in sawtooth mode, the next tick loads ramp_lo and the state stays UP.
REQ-022 DOWN on tick: duty = max(duty - ramp_step, ramp_lo), computed with a 9-bit borrow check; on reaching ramp_lo, the next state is UP.
REQ-023 ramp_step = 0: duty holds and the state does not change.
REQ-024 ramp_lo >= ramp_hi: duty is forced to ramp_lo on each tick and the state remains UP.
REQ-025 Host write to 0x04 coincident with a tick: the host value wins, the tick is discarded, wr_collision pulses, and ramping continues from the written value on the next tick.
REQ-026 Host write to 0x04 while IDLE: plain register write.
REQ-027 Writes to 0x06-0x09 while ramping take effect from the next tick; the state does not change.
REQ-028 Writes to the 0x00-0x03 enable registers never interact with the ramp engine.

Reset
REQ-029 While rst is high: all registers = 0x00, pwm_duty_cycle = 0x00, state = IDLE, tick counter = 0, ramp_active = 0, wr_collision = 0.
REQ-030 Reset asserted mid-ramp aborts the ramp immediately (asynchronous).
REQ-031 After reset deassertion, the ramp stays in IDLE until a new enable write arrives.

Structure
REQ-032 Shared package pwm_ctrl_pkg holds the register address constants (ADDR_EN_OUT_LO .. ADDR_RAMP_HI), the state enumeration, and the ramp_ctrl bit positions.
REQ-033 One sub-module, ramp_tick_gen, contains the prescale counter and tick output, with a clear input; all other logic lives in pwm_ramp_ctrl.

Verification
REQ-034 Triangle: lo=0x10, hi=0x40, step=0x10, div=3, enable -> duty 0x10, 0x20, 0x30, 0x40, 0x30, 0x20, 0x10, 0x20, changing every 4 cycles.
REQ-035 Saturation: lo=0x00, hi=0xFF, step=0x60, triangle -> duty 0x00, 0x60, 0xC0, 0xFF, 0x9F, 0x3F, 0x00, with no wrap.
REQ-036 Sawtooth: lo=0x10, hi=0x30, step=0x10 -> duty 0x10, 0x20, 0x30, 0x10, 0x20.
REQ-037 Collision: host writes 0x04 = 0x80 on a tick cycle during UP (step 0x10) -> duty 0x80 and a one-cycle wr_collision pulse, then 0x90 at the next tick.
REQ-038 Disable, then reset mid-ramp:
- Write 0x05 = 0x00 at duty 0x30 -> duty holds 0x30 and ramp_active = 0 next cycle.
- Assert rst mid-ramp -> all outputs 0x00 with no clock edge needed.
REQ-039 Invalid and step-zero cases:
- Write to 0x0A = 0x55 -> no output changes.
- step=0 while ramping -> duty constant over 10 ticks.
